// File: rtl/mem_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : mem_dump_reader
// Description : Walks data memory words 0..NUM_WORDS-1 through the memory
//               read port and streams each word out MSB byte first over a
//               valid/ready byte interface feeding the debug UART.
//               Optional feature macro: MEM_DUMP_CHECKSUM_EN appends an XOR
//               checksum byte of all data bytes after the last word.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_dump_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_WORDS  = 10
) (
    input  logic                  clka,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BCW-1:0]        LAST_BYTE = BCW'(BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
`ifdef MEM_DUMP_CHECKSUM_EN
        ,
        CSUM = 2'd3
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic [BCW-1:0]          bcnt_q, bcnt_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    xfer;
    logic [7:0]              head_byte;

`ifdef MEM_DUMP_CHECKSUM_EN
    logic [7:0]              csum_q, csum_d;
`endif

    // The byte on the wire is always the top of the shift register, so it
    // stays stable under backpressure without any extra holding register.
    assign head_byte = shreg_q[DATA_WIDTH-1 -: 8];
    assign xfer      = valid_q && tx_ready;

    // Next-state and datapath update; a transfer is the only event in SEND.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        shreg_d = shreg_q;
        bcnt_d  = bcnt_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    addr_d  = '0;
                    busy_d  = 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            LOAD: begin
                shreg_d = mem_rdata;
                bcnt_d  = '0;
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (xfer) begin
                    shreg_d = shreg_q << 8;
                    bcnt_d  = bcnt_q + 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
                    csum_d  = csum_q ^ head_byte;
`endif
                    if (bcnt_q == LAST_BYTE) begin
                        bcnt_d  = '0;
                        valid_d = 1'b0;
                        if (addr_q != LAST_WORD) begin
                            addr_d  = addr_q + 1'b1;
                            state_d = LOAD;
                        end else begin
`ifdef MEM_DUMP_CHECKSUM_EN
                            // Checksum byte follows immediately; valid stays up.
                            valid_d = 1'b1;
                            state_d = CSUM;
`else
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
`endif
                        end
                    end
                end
            end
`ifdef MEM_DUMP_CHECKSUM_EN
            CSUM: begin
                if (xfer) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any dump in progress.
    always_ff @(posedge clka) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            shreg_q <= '0;
            bcnt_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            shreg_q <= shreg_d;
            bcnt_q  <= bcnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MEM_DUMP_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

`ifdef MEM_DUMP_CHECKSUM_EN
    assign tx_data = (state_q == CSUM) ? csum_q : head_byte;
`else
    assign tx_data = head_byte;
`endif

    assign mem_addr = addr_q;
    assign tx_valid = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: doc/mem_dump_reader.md
# mem_dump_reader

Sequential read-out engine for the 16×32 data memory debug path. On a start pulse it walks memory words `0..NUM_WORDS-1` through the memory read port, captures each word and streams it out byte-by-byte, MSB first, over a valid/ready byte interface. It sits between the data memory read port and the debug UART transmitter, replacing the wide parallel memory dump bus with a serial byte stream.

## Interface
- `DATA_WIDTH`, 32, memory word width; must be a multiple of 8.
- `ADDR_WIDTH`, 4, memory address width.
- `NUM_WORDS`, 10, number of words dumped, starting at address 0; range 1..2**ADDR_WIDTH.

- `clka`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  dump request, sampled only in IDLE.
- `mem_addr`  out  ADDR_WIDTH  registered read address to memory.
- `mem_rdata`  in  DATA_WIDTH  memory read data, combinational from `mem_addr`.
- `tx_data`  out  8  byte to transmitter.
- `tx_valid`  out  1  byte available.
- `tx_ready`  in  1  transmitter accepts byte.
- `busy`  out  1  high from the cycle after start until dump end.
- `done`  out  1  one-cycle pulse after the final byte is accepted.

## Operation
- States: IDLE, LOAD, SEND, CSUM (CSUM exists only with the macro).
- IDLE: `start`=1 → LOAD, `mem_addr`=0, `busy`=1, word counter=0. `start` is ignored outside IDLE.
- LOAD: capture `mem_rdata` into the shift register, byte counter=0, → SEND with `tx_valid`=1 and `tx_data`=captured word[DATA_WIDTH-1:DATA_WIDTH-8].
- SEND: a transfer occurs on an edge where `tx_valid` and `tx_ready` are both high. On each transfer the register shifts left 8 bits and the byte counter increments.
  - On the last byte of the word (`DATA_WIDTH/8` bytes), if the word is not the last: `mem_addr`+1, `tx_valid`=0, → LOAD.
  - If it is the last word: → IDLE (or CSUM), `tx_valid`=0, `busy`=0, `done`=1.
- While `tx_valid`=1 and `tx_ready`=0, `tx_data` holds stable. `tx_valid` never drops without a transfer.
- `mem_addr` holds its last value in IDLE. The counters do not wrap past `NUM_WORDS-1`.
- Reset at any time: next edge gives state=IDLE, `mem_addr`=0, `tx_data`=0, `tx_valid`=0, `busy`=0, `done`=0, checksum=0. A partial dump is abandoned and does not resume.

## Timing
- Reset values: all outputs 0.
- `start` sampled at edge E0. After E0: `busy`=1, `mem_addr`=0. After E1: `tx_valid`=1 with word 0's MSB byte.
- With `tx_ready` held high, each word takes 1 LOAD cycle plus DATA_WIDTH/8 SEND cycles, which is 5 cycles at the defaults. The last byte of word k transfers at E(5+5k).
- Defaults, no macro: the final transfer is at E50. `done`=1 and `busy`=0 in the cycle following E50. `done` returns to 0 after E51.
- Backpressure adds exactly one cycle per cycle that `tx_ready` is low while `tx_valid` is high.
- `start` asserted in the same cycle `done` is high is accepted, because the state is already IDLE.

## Configuration
- `MEM_DUMP_CHECKSUM_EN` defined: a running XOR of every transferred byte is kept, cleared on start.
  - After the last data byte, the state goes to CSUM: `tx_valid`=1 and `tx_data`=the XOR of all data bytes.
  - On that transfer: → IDLE, `done`=1, `busy`=0. The dump is one byte longer, and `done` follows the checksum transfer.
- Undefined: no checksum register, no CSUM state. `done` follows the last data byte.

## Test plan
- Reset with the bench holding `start`=0: all outputs 0. Pulse `reset` during IDLE: outputs remain 0.
- Memory words 0..9 = 0x11223344 + k×0x01010101, `tx_ready`=1, `start` pulse at E0:
  - 40 bytes are received: 11 22 33 44 12 23 34 45 …
  - `done` is high only in the cycle after E50.
- Backpressure: `tx_ready`=0 for 3 cycles while `tx_data`=0x22. `tx_data` and `tx_valid` hold stable, then the next byte is 0x33. `done` is delayed by 3 cycles.
- `start` re-pulsed at E20 during a dump: no effect, and the byte stream is identical to the previous test.
- `reset` at E23 (mid-SEND, word 4): next cycle `tx_valid`=0, `busy`=0, `mem_addr`=0. A new `start` dumps again from word 0.
- `MEM_DUMP_CHECKSUM_EN`, words 0..9 = 0x01020304: 41 bytes received, last byte 0x00 (the XOR of 0x01, 0x02, 0x03 and 0x04 taken ten times, an even count, is 0). With word 0 = 0x01020305 instead, the last byte is 0x01. `done` is high in the cycle after E51.
